// File: rtl/aes_word_packer_if.sv
// Word-stream handshake and block-issue bundle between the upstream feeder,
// the word packer and the AES pipeline input.
interface aes_word_packer_if #(
    parameter int WORD_LEN = 32,
    parameter int DATA_LEN = 128,
    parameter int KEY_LEN  = 128
);
    logic                in_valid;
    logic                in_ready;
    logic [WORD_LEN-1:0] in_word;
    logic                in_sel;
    logic                hold;
    logic                data_valid_in;
    logic                key_valid_in;
    logic [DATA_LEN-1:0] plain_text;
    logic [KEY_LEN-1:0]  cipher_key;
    logic                key_loaded;
    logic                err_no_key;
    logic                err_frame;
    logic [15:0]         blk_count;

    modport master (
        output in_valid, in_word, in_sel, hold,
        input  in_ready, data_valid_in, key_valid_in, plain_text, cipher_key,
               key_loaded, err_no_key, err_frame, blk_count
    );

    modport slave (
        input  in_valid, in_word, in_sel, hold,
        output in_ready, data_valid_in, key_valid_in, plain_text, cipher_key,
               key_loaded, err_no_key, err_frame, blk_count
    );
endinterface

// File: rtl/aes_word_packer.sv
// Packs a 32-bit key/plaintext word stream into 128-bit blocks and issues each
// completed plaintext block with the stored key as a one-cycle pulse.
module aes_word_packer #(
    parameter int WORD_LEN = 32,
    parameter int DATA_LEN = 128,
    parameter int KEY_LEN  = 128
) (
    input  logic              clk,
    input  logic              reset,
    aes_word_packer_if.slave  bus
);
    localparam int WPB = DATA_LEN / WORD_LEN;
    localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;

    typedef enum logic {S_FILL, S_HOLD} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_LEN-1:0] r_asm, r_pend, r_pt;
    logic [KEY_LEN-1:0]  r_key, r_ck;
    logic [CW-1:0]       r_wcnt;
    logic                r_cur_sel, r_key_loaded, r_dv, r_err_nk, r_err_fr;
    logic [15:0]         r_blk_cnt;

    logic                w_ready, w_acc, w_switch, w_last;
    logic                w_key_done, w_data_done;
    logic                w_issue_now, w_issue_pend, w_to_hold, w_drop;
    logic [CW-1:0]       w_pos;
    logic [DATA_LEN-1:0] w_asm_nxt;

    assign w_ready     = (r_state == S_FILL) && reset;
    assign w_acc       = bus.in_valid && w_ready;
    assign w_switch    = w_acc && (r_wcnt != '0) && (bus.in_sel != r_cur_sel);
    // A type switch restarts the assembly, so the accepted word counts as word 0.
    assign w_pos       = w_switch ? '0 : r_wcnt;
    assign w_last      = w_acc && (w_pos == CW'(WPB - 1));
    assign w_asm_nxt   = {r_asm[DATA_LEN-WORD_LEN-1:0], bus.in_word};
    assign w_key_done  = w_last && bus.in_sel;
    assign w_data_done = w_last && !bus.in_sel;

    always_comb begin
        w_state_nxt  = r_state;
        w_issue_now  = 1'b0;
        w_issue_pend = 1'b0;
        w_to_hold    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_data_done) begin
                    if (!r_key_loaded) begin
                        w_drop = 1'b1;
                    end else if (!bus.hold) begin
                        w_issue_now = 1'b1;
                    end else begin
                        w_to_hold   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!bus.hold) begin
                    w_issue_pend = 1'b1;
                    w_state_nxt  = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_FILL;
            r_asm        <= '0;
            r_pend       <= '0;
            r_pt         <= '0;
            r_key        <= '0;
            r_ck         <= '0;
            r_wcnt       <= '0;
            r_cur_sel    <= 1'b0;
            r_key_loaded <= 1'b0;
            r_dv         <= 1'b0;
            r_err_nk     <= 1'b0;
            r_err_fr     <= 1'b0;
            r_blk_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dv     <= w_issue_now || w_issue_pend;
            r_err_fr <= w_switch;
            r_err_nk <= w_drop;
            if (w_acc) begin
                r_asm     <= w_asm_nxt;
                r_cur_sel <= bus.in_sel;
                r_wcnt    <= w_last ? '0 : w_pos + CW'(1);
            end
            if (w_key_done) begin
                r_key        <= w_asm_nxt;
                r_key_loaded <= 1'b1;
            end
            if (w_to_hold) r_pend <= w_asm_nxt;
            if (w_issue_now) begin
                r_pt <= w_asm_nxt;
                r_ck <= r_key;
            end else if (w_issue_pend) begin
                r_pt <= r_pend;
                r_ck <= r_key;
            end
            if (w_issue_now || w_issue_pend) r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

    assign bus.in_ready      = w_ready;
    assign bus.data_valid_in = r_dv;
    assign bus.key_valid_in  = r_dv;
    assign bus.plain_text    = r_pt;
    assign bus.cipher_key    = r_ck;
    assign bus.key_loaded    = r_key_loaded;
    assign bus.err_no_key    = r_err_nk;
    assign bus.err_frame     = r_err_fr;
    assign bus.blk_count     = r_blk_cnt;
endmodule

// File: tb/tb_aes_word_packer.sv
// Table-driven bench with a block scoreboard for aes_word_packer.
module tb_aes_word_packer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aes_word_packer_if #(.WORD_LEN(32), .DATA_LEN(128), .KEY_LEN(128)) bus ();

    aes_word_packer #(.WORD_LEN(32), .DATA_LEN(128), .KEY_LEN(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        sel;
        logic [31:0] w;
        logic        hold;
        logic        e_fr;
        logic        e_nk;
        logic        e_pl;
    } vec_t;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ck;
    } blk_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    blk_t sb[$];

    // Bench-side reference state for block contents and key.
    logic [127:0] m_buf, m_key, m_pend;
    int           m_cnt;
    logic         m_sel, m_kl;
    int           m_blk;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_buf = '0; m_key = '0; m_pend = '0;
        m_cnt = 0; m_sel = 1'b0; m_kl = 1'b0; m_blk = 0;
    endfunction

    always @(negedge clk) begin
        if (bus.data_valid_in || bus.key_valid_in) begin
            chk("key_valid_eq_data_valid", {127'd0, bus.key_valid_in}, {127'd0, bus.data_valid_in});
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pt=%h expected no issue", bus.plain_text);
            end else begin
                blk_t e;
                e = sb.pop_front();
                chk("sb_plain_text", bus.plain_text, e.pt);
                chk("sb_cipher_key", bus.cipher_key, e.ck);
            end
        end
    end

    task automatic send(input logic sel, input logic [31:0] w, input logic h,
                        input logic e_fr, input logic e_nk, input logic e_pl);
        blk_t b;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_word  = w;
        bus.hold     = h;
        chk("in_ready_before_accept", {127'd0, bus.in_ready}, 128'd1);
        if (m_cnt != 0 && sel != m_sel) m_cnt = 0;
        m_buf = {m_buf[95:0], w};
        m_sel = sel;
        m_cnt++;
        if (m_cnt == 4) begin
            m_cnt = 0;
            if (sel) begin
                m_key = m_buf;
                m_kl  = 1'b1;
            end else if (m_kl && !h) begin
                b.pt = m_buf; b.ck = m_key;
                sb.push_back(b);
                m_blk++;
            end else if (m_kl) begin
                m_pend = m_buf;
            end
        end
        @(posedge clk); #1;
        chk("err_frame",     {127'd0, bus.err_frame},     {127'd0, e_fr});
        chk("err_no_key",    {127'd0, bus.err_no_key},    {127'd0, e_nk});
        chk("data_valid_in", {127'd0, bus.data_valid_in}, {127'd0, e_pl});
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.hold = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_in_reset", {127'd0, bus.in_ready}, 128'd0);
        @(posedge clk); #1;
        chk("rst_plain_text", bus.plain_text, 128'd0);
        chk("rst_cipher_key", bus.cipher_key, 128'd0);
        chk("rst_key_loaded", {127'd0, bus.key_loaded}, 128'd0);
        chk("rst_blk_count",  {112'd0, bus.blk_count}, 128'd0);
        chk("rst_pulses", {125'd0, bus.data_valid_in, bus.err_no_key, bus.err_frame}, 128'd0);
        model_reset();
        reset = 1'b1;
        #1;
        chk("in_ready_after_release", {127'd0, bus.in_ready}, 128'd1);
    endtask

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{1'b0, 32'h3243f6a8, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h885a308d, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h313198a2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'he0370734, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'h00010203, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h04050607, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h08090a0b, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 32'h0c0d0e0f, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'h00112233, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h44556677, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h8899aabb, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'hccddeeff, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 32'haaaa0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 32'haaaa0001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 32'h2b7e1516, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 32'h28aed2a6, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 32'habf71588, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 32'h09cf4f3c, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 32'h6bc1bee2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 32'h2e409f96, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 32'he93d7e11, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 32'h7393172a, 1'b0, 1'b0, 1'b0, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_word  = '0;
        bus.hold     = 1'b0;
        model_reset();
        do_reset();

        for (int i = 0; i < 22; i++) begin
            send(tbl[i].sel, tbl[i].w, tbl[i].hold, tbl[i].e_fr, tbl[i].e_nk, tbl[i].e_pl);
            if (i == 3) chk("blk_count_no_key", {112'd0, bus.blk_count}, 128'd0);
            if (i == 11) begin
                chk("kd_plain_text", bus.plain_text, 128'h00112233445566778899aabbccddeeff);
                chk("kd_cipher_key", bus.cipher_key, 128'h000102030405060708090a0b0c0d0e0f);
                chk("kd_blk_count",  {112'd0, bus.blk_count}, 128'd1);
            end
            if (i == 17) chk("frame_key_loaded", {127'd0, bus.key_loaded}, 128'd1);
        end
        chk("frame_key_used", bus.cipher_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        idle(1);

        // Hold on the completing word, release six cycles later.
        send(1'b0, 32'h3243f6a8, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 32'h885a308d, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 32'h313198a2, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 32'he0370734, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("hold_in_ready", {127'd0, bus.in_ready}, 128'd0);
            @(posedge clk); #1;
            chk("hold_no_pulse", {127'd0, bus.data_valid_in}, 128'd0);
        end
        bus.hold = 1'b0;
        begin
            blk_t b;
            b.pt = m_pend; b.ck = m_key;
            sb.push_back(b);
            m_blk++;
        end
        @(posedge clk); #1;
        chk("hold_release_pulse", {127'd0, bus.data_valid_in}, 128'd1);
        chk("hold_release_pt", bus.plain_text, 128'h3243f6a8885a308d313198a2e0370734);
        chk("hold_release_ready", {127'd0, bus.in_ready}, 128'd1);
        chk("hold_blk_count", {112'd0, bus.blk_count}, 128'(m_blk));
        idle(1);
        chk("hold_pulse_one_cycle", {127'd0, bus.data_valid_in}, 128'd0);

        // Streaming: three back-to-back blocks with in_valid held high.
        do_reset();
        send(1'b1, 32'h00010203, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b1, 32'h04050607, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b1, 32'h08090a0b, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b1, 32'h0c0d0e0f, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++)
            for (int j = 0; j < 4; j++)
                send(1'b0, {8'(b + 1), 8'(j), 16'hbeef}, 1'b0, 1'b0, 1'b0, (j == 3));
        chk("stream_blk_count", {112'd0, bus.blk_count}, 128'd3);

        // Reset in the middle of a block: nothing partial survives.
        send(1'b0, 32'hdead0001, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 32'hdead0002, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        idle(6);
        send(1'b0, 32'hcafe0001, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 32'hcafe0002, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 32'hcafe0003, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 32'hcafe0004, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_reset_blk_count", {112'd0, bus.blk_count}, 128'd0);
        idle(4);

        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_word_packer.md
# aes_word_packer

Upstream feeder for the AES pipeline top (`TOP`). It accepts a 32-bit word stream with a valid/ready handshake and assembles 128-bit key and plaintext blocks. It keeps the most recently loaded cipher key. For every completed plaintext block it issues a one-cycle `data_valid_in`/`key_valid_in` pulse carrying that block and the stored key, which is exactly the packet format the pipeline accepts. The pipeline cannot stall, so this block provides the only flow-control point (`hold`).

## Interface
Parameters:
- `WORD_LEN`, 32: input word width.
- `DATA_LEN`, 128: plaintext block width. Must be an integer multiple of `WORD_LEN`.
- `KEY_LEN`, 128: cipher key width. Must equal `DATA_LEN` in this revision.
- `WPB`, `DATA_LEN/WORD_LEN` (4): words per block. Derived localparam.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  word offered.
- `in_ready`  out  1  word can be accepted.
- `in_word`  in  `WORD_LEN`  payload word. The first word of a block lands in the MSBs.
- `in_sel`  in  1  word type: 0 = plaintext, 1 = key.
- `hold`  in  1  downstream pause request.
- `data_valid_in`  out  1  pulse to `TOP.data_valid_in`.
- `key_valid_in`  out  1  pulse to `TOP.key_valid_in`; always equal to `data_valid_in`.
- `plain_text`  out  `DATA_LEN`  assembled plaintext block.
- `cipher_key`  out  `KEY_LEN`  stored key presented with the block.
- `key_loaded`  out  1  a full key has been assembled since reset.
- `err_no_key`  out  1  one-cycle pulse: a plaintext block was dropped because no key was loaded.
- `err_frame`  out  1  one-cycle pulse: a partial assembly was discarded.
- `blk_count`  out  16  number of issued blocks; wraps modulo 2^16.

## Operation
- Accept: a word is accepted on a rising edge when `in_valid && in_ready`.
- Assembly:
  - A shift register takes each accepted word with `asm <= {asm[DATA_LEN-WORD_LEN-1:0], in_word}`.
  - A 2-bit word counter `wcnt` (0..WPB-1) and a register `cur_sel` record the type of the assembly in progress.
- Type switch:
  - Condition: a word is accepted with `wcnt != 0` and `in_sel != cur_sel`.
  - The partial assembly is discarded and `err_frame` pulses.
  - The accepted word becomes word 0 of a new assembly of the new type, and `wcnt` becomes 1.
- Key completion (4th key word accepted):
  - `key_reg <= assembled key` and `key_loaded <= 1`. No output pulse.
  - A later key replaces the stored key for all subsequently issued blocks.
- Data completion (4th data word accepted):
  - If `key_loaded == 0`: the block is dropped, `err_no_key` pulses, and the state stays FILL.
  - Otherwise, if `hold == 0` on that same edge: the outputs register the block and pulse the next cycle.
  - Otherwise (`hold == 1`): the block is latched and the state moves to HOLD.
- FSM:
  - FILL: `in_ready = 1`.
  - HOLD: `in_ready = 0`. The pending block is kept. On the first edge that samples `hold == 0`, the block issues and the state returns to FILL.
- Issue:
  - `data_valid_in = key_valid_in = 1` for exactly one cycle.
  - `plain_text` and `cipher_key` hold the block and key during the pulse and keep those values afterwards until the next issue.
  - `blk_count` increments on the issue edge.
- `in_ready` is derived from the state register only. It is forced to 0 while `reset == 0`.

## Timing
- Reset (`reset == 0` on an edge):
  - State = FILL, `wcnt = 0`, `key_loaded = 0`, `blk_count = 0`.
  - `plain_text = 0`, `cipher_key = 0`.
  - All pulse outputs = 0.
  - Any partial assembly or held block is lost.
  - `in_ready` is 0 while reset is low and 1 in the first cycle after release.
- Latency:
  - 4th data word accepted at edge N with `hold == 0`: the pulse is high in cycle N+1 (registered after edge N).
  - HOLD exit at edge M: the pulse is high in cycle M+1.
- Throughput: one block per 4 cycles under continuous `in_valid` with `hold == 0`. There is no bubble between blocks.
- Back-to-back issue: after a HOLD exit, FILL resumes at edge M. A following block can therefore issue no earlier than cycle M+5, so two pulses are never adjacent.
- `err_no_key` and `err_frame`: registered, high in the cycle after the offending accept. They are mutually exclusive by construction.
- `blk_count` wrap: 16'hFFFF increments to 16'h0000, with no flag.

## Test plan
- Key then data:
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then data words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required: one pulse with `plain_text = 00112233445566778899aabbccddeeff` and `cipher_key = 000102030405060708090a0b0c0d0e0f`, one cycle after the 8th accept; `blk_count = 1`.
- No key:
  - Stimulus: four data words 3243f6a8, 885a308d, 313198a2, e0370734 after reset.
  - Required: `err_no_key` pulses; no `data_valid_in`; `blk_count = 0`.
- Hold:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c loaded, `hold = 1` during the 4th data word, `hold` released 6 cycles later.
  - Required: `in_ready = 0` for those cycles; one pulse in the cycle after release with the correct block.
- Frame error:
  - Stimulus: 2 data words, then a key word.
  - Required: `err_frame` pulses; the key assembly completes after 3 more key words; no data issue.
- Streaming and reset:
  - Stimulus: three consecutive 4-word data blocks with `in_valid` held high.
  - Required: pulses exactly 4 cycles apart, `blk_count = 3`.
  - Stimulus: assert `reset = 0` mid-block.
  - Required: all outputs return to their reset values and the partial block never issues.
